// File: rtl/linebuf_pkg.sv
// Shared defaults and helpers for the N-row line buffer.
package linebuf_pkg;

    localparam int unsigned LB_NUM_LINES  = 3;
    localparam int unsigned LB_DATA_WIDTH = 16;
    localparam int unsigned LB_MAX_LENGTH = 100;
    localparam int unsigned LB_ADDR_WIDTH = 7;
    localparam int unsigned LB_FILL_WIDTH = $clog2(LB_NUM_LINES);

    // Width of a counter that must reach num_lines-1.
    function automatic int unsigned fill_width(input int unsigned num_lines);
        return (num_lines < 2) ? 1 : $clog2(num_lines);
    endfunction

    // Zero or oversize line lengths fall back to the full memory depth.
    function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_len);
        return ((len == 0) || (len > max_len)) ? max_len : len;
    endfunction

endpackage

// File: rtl/linebuf_ram.sv
// One line memory: combinational read, synchronous write, no reset on contents.
module linebuf_ram
    import linebuf_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = LB_DATA_WIDTH,
    parameter int unsigned MAX_LENGTH = LB_MAX_LENGTH,
    localparam int unsigned AW = (MAX_LENGTH > 1) ? $clog2(MAX_LENGTH) : 1
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [AW-1:0]         i_addr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [MAX_LENGTH];

    assign o_rdata = r_mem[i_addr];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

endmodule

// File: rtl/linebuf_nrow.sv
// N-row line buffer: raster pixels in, vertically aligned columns out,
// with runtime line length, frame restart and valid/ready on both sides.
module linebuf_nrow
    import linebuf_pkg::*;
#(
    parameter int unsigned NUM_LINES  = LB_NUM_LINES,
    parameter int unsigned DATA_WIDTH = LB_DATA_WIDTH,
    parameter int unsigned MAX_LENGTH = LB_MAX_LENGTH,
    parameter int unsigned ADDR_WIDTH = LB_ADDR_WIDTH
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            sof,
    input  logic [ADDR_WIDTH-1:0]           line_len,
    input  logic [DATA_WIDTH-1:0]           data_in,
    input  logic                            in_valid,
    output logic                            in_ready,
    output logic [NUM_LINES*DATA_WIDTH-1:0] data_out,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic                            out_sof,
    output logic                            out_eol
);

    localparam int unsigned FILL_W = fill_width(NUM_LINES);
    localparam int unsigned RAM_AW = (MAX_LENGTH > 1) ? $clog2(MAX_LENGTH) : 1;
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(NUM_LINES - 1);

    logic [ADDR_WIDTH-1:0]           r_col;
    logic [ADDR_WIDTH-1:0]           r_len;
    logic [FILL_W-1:0]               r_fill;
    logic                            r_sof_pend;
    logic                            r_out_valid;
    logic                            r_out_sof;
    logic                            r_out_eol;
    logic [NUM_LINES*DATA_WIDTH-1:0] r_data_out;

    logic                            w_accept;
    logic [ADDR_WIDTH-1:0]           w_col_eff;
    logic [ADDR_WIDTH-1:0]           w_len_eff;
    logic [FILL_W-1:0]               w_fill_eff;
    logic                            w_wrap;
    logic [ADDR_WIDTH-1:0]           w_col_nxt;
    logic [FILL_W-1:0]               w_fill_nxt;
    logic                            w_valid_nxt;
    logic [RAM_AW-1:0]               w_addr;
    logic [NUM_LINES*DATA_WIDTH-1:0] w_data_nxt;
    logic [DATA_WIDTH-1:0]           w_rd [NUM_LINES-1];
    logic [DATA_WIDTH-1:0]           w_wr [NUM_LINES-1];

    assign in_ready  = !r_out_valid || out_ready;
    assign data_out  = r_data_out;
    assign out_valid = r_out_valid;
    assign out_sof   = r_out_sof;
    assign out_eol   = r_out_eol;

    // A sof beat restarts the row at column 0 and the fill count at row 0.
    always_comb begin
        w_accept    = in_valid && in_ready;
        w_col_eff   = sof ? '0 : r_col;
        w_fill_eff  = sof ? '0 : r_fill;
        w_len_eff   = sof ? ADDR_WIDTH'(clamp_len(32'(line_len), MAX_LENGTH)) : r_len;
        w_wrap      = (w_col_eff == (w_len_eff - ADDR_WIDTH'(1)));
        w_col_nxt   = w_wrap ? '0 : (w_col_eff + ADDR_WIDTH'(1));
        w_fill_nxt  = (w_wrap && (w_fill_eff != FILL_MAX)) ? (w_fill_eff + FILL_W'(1)) : w_fill_eff;
        w_valid_nxt = (w_fill_eff == FILL_MAX);
        w_addr      = RAM_AW'(w_col_eff);
    end

    // Column assembly: slice 0 is the incoming pixel, slice k comes from memory k-1.
    always_comb begin
        w_data_nxt = '0;
        w_data_nxt[DATA_WIDTH-1:0] = data_in;
        for (int k = 1; k < NUM_LINES; k++) begin
            w_data_nxt[k*DATA_WIDTH +: DATA_WIDTH] = w_rd[k-1];
        end
    end

    for (genvar k = 0; k < NUM_LINES - 1; k++) begin : g_line
        if (k == 0) begin : g_head
            assign w_wr[k] = data_in;
        end else begin : g_tail
            assign w_wr[k] = w_rd[k-1];
        end

        linebuf_ram #(
            .DATA_WIDTH (DATA_WIDTH),
            .MAX_LENGTH (MAX_LENGTH)
        ) u_ram (
            .clk     (clk),
            .i_we    (w_accept),
            .i_addr  (w_addr),
            .i_wdata (w_wr[k]),
            .o_rdata (w_rd[k])
        );
    end

    // Counters and output register; output holds while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col       <= '0;
            r_len       <= ADDR_WIDTH'(MAX_LENGTH);
            r_fill      <= '0;
            r_sof_pend  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_sof   <= 1'b0;
            r_out_eol   <= 1'b0;
            r_data_out  <= '0;
        end else if (w_accept) begin
            r_col       <= w_col_nxt;
            r_len       <= w_len_eff;
            r_fill      <= w_fill_nxt;
            r_sof_pend  <= (sof || r_sof_pend) && !w_valid_nxt;
            r_out_valid <= w_valid_nxt;
            r_out_sof   <= w_valid_nxt && (sof || r_sof_pend);
            r_out_eol   <= w_wrap;
            r_data_out  <= w_data_nxt;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
            r_out_sof   <= 1'b0;
            r_out_eol   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_linebuf_nrow.sv
// Directed bench for linebuf_nrow: a 3-row instance for most scenarios and a 5-row instance.
module tb_linebuf_nrow;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 7;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          sof = 1'b0;
    logic [AW-1:0] line_len = '0;
    logic [DW-1:0] data_in = '0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b1;
    logic          in_ready, out_valid, out_sof, out_eol;
    logic [3*DW-1:0] data_out;

    logic          sof5 = 1'b0;
    logic [AW-1:0] line_len5 = '0;
    logic [DW-1:0] data_in5 = '0;
    logic          in_valid5 = 1'b0;
    logic          out_ready5 = 1'b1;
    logic          in_ready5, out_valid5, out_sof5, out_eol5;
    logic [5*DW-1:0] data_out5;

    int errors = 0;
    int checks = 0;

    linebuf_nrow #(.NUM_LINES(3), .DATA_WIDTH(DW), .MAX_LENGTH(100), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n), .sof(sof), .line_len(line_len), .data_in(data_in),
        .in_valid(in_valid), .in_ready(in_ready), .data_out(data_out), .out_valid(out_valid),
        .out_ready(out_ready), .out_sof(out_sof), .out_eol(out_eol)
    );

    linebuf_nrow #(.NUM_LINES(5), .DATA_WIDTH(DW), .MAX_LENGTH(100), .ADDR_WIDTH(AW)) dut5 (
        .clk(clk), .rst_n(rst_n), .sof(sof5), .line_len(line_len5), .data_in(data_in5),
        .in_valid(in_valid5), .in_ready(in_ready5), .data_out(data_out5), .out_valid(out_valid5),
        .out_ready(out_ready5), .out_sof(out_sof5), .out_eol(out_eol5)
    );

    function automatic logic [DW-1:0] pix(input int tag, input int row, input int col);
        return DW'(tag * 4096 + row * 128 + col);
    endfunction

    task automatic push(input logic s, input logic [AW-1:0] len, input logic [DW-1:0] p);
        @(negedge clk);
        sof = s; line_len = len; data_in = p; in_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic push5(input logic s, input logic [AW-1:0] len, input logic [DW-1:0] p);
        @(negedge clk);
        sof5 = s; line_len5 = len; data_in5 = p; in_valid5 = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0; sof = 1'b0; in_valid5 = 1'b0; sof5 = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Streams nrows full rows plus `extra` beats, checking each output column.
    task automatic test_frame(input string name, input int len_in, input int len_eff,
                              input int nrows, input int extra, input int tag);
        logic [3*DW-1:0] exp;
        for (int r = 0; r <= nrows; r++) begin
            int ncol;
            ncol = (r == nrows) ? extra : len_eff;
            for (int c = 0; c < ncol; c++) begin
                push((r == 0) && (c == 0), AW'(len_in), pix(tag, r, c));
                checks++;
                if (r < 2) begin
                    if (out_valid !== 1'b0) begin
                        errors++;
                        $display("FAIL %s prime r%0d c%0d: out_valid=%b want 0", name, r, c, out_valid);
                    end
                end else begin
                    exp = {pix(tag, r-2, c), pix(tag, r-1, c), pix(tag, r, c)};
                    if (out_valid !== 1'b1 || data_out !== exp ||
                        out_sof !== ((r == 2) && (c == 0)) || out_eol !== (c == len_eff - 1)) begin
                        errors++;
                        $display("FAIL %s r%0d c%0d: valid=%b sof=%b eol=%b data=%h, want valid=1 sof=%b eol=%b data=%h",
                                 name, r, c, out_valid, out_sof, out_eol, data_out,
                                 (r == 2) && (c == 0), c == len_eff - 1, exp);
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_sof !== 1'b0 || out_eol !== 1'b0 || data_out !== '0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset: valid=%b sof=%b eol=%b data=%h in_ready=%b, want 0 0 0 0 1",
                     out_valid, out_sof, out_eol, data_out, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || data_out !== '0) begin
            errors++;
            $display("FAIL reset_idle: valid=%b data=%h, want 0 0", out_valid, data_out);
        end
    endtask

    task automatic test_priming();
        test_frame("priming", 4, 4, 3, 0, 0);
        idle();
    endtask

    task automatic test_backpressure();
        logic [3*DW-1:0] held;
        logic [3*DW-1:0] exp;
        test_frame("bp_pre", 4, 4, 3, 2, 1);
        held = {pix(1, 1, 1), pix(1, 2, 1), pix(1, 3, 1)};
        @(negedge clk);
        out_ready = 1'b0; sof = 1'b0; data_in = pix(1, 3, 2); in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || data_out !== held) begin
                errors++;
                $display("FAIL bp_hold cyc%0d: in_ready=%b valid=%b data=%h, want 0 1 %h",
                         i, in_ready, out_valid, data_out, held);
            end
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        exp = {pix(1, 1, 2), pix(1, 2, 2), pix(1, 3, 2)};
        checks++;
        if (out_valid !== 1'b1 || data_out !== exp || out_eol !== 1'b0) begin
            errors++;
            $display("FAIL bp_resume c2: valid=%b eol=%b data=%h, want 1 0 %h", out_valid, out_eol, data_out, exp);
        end
        push(1'b0, AW'(4), pix(1, 3, 3));
        exp = {pix(1, 1, 3), pix(1, 2, 3), pix(1, 3, 3)};
        checks++;
        if (out_valid !== 1'b1 || data_out !== exp || out_eol !== 1'b1) begin
            errors++;
            $display("FAIL bp_resume c3: valid=%b eol=%b data=%h, want 1 1 %h", out_valid, out_eol, data_out, exp);
        end
        idle();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_drain: valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_len_change();
        test_frame("len2", 2, 2, 3, 0, 2);
        idle();
    endtask

    task automatic test_clamp();
        test_frame("clamp0", 0, 100, 3, 0, 3);
        test_frame("clamp120", 120, 100, 3, 0, 4);
        idle();
    endtask

    task automatic test_sof_mid();
        test_frame("mid_old", 4, 4, 3, 2, 5);
        test_frame("mid_new", 4, 4, 3, 0, 6);
        idle();
    endtask

    task automatic test_len1();
        test_frame("len1", 1, 1, 4, 0, 7);
        idle();
    endtask

    task automatic test_async_reset();
        test_frame("rst_pre", 4, 4, 2, 2, 8);
        @(negedge clk);
        in_valid = 1'b0; sof = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_sof !== 1'b0 || out_eol !== 1'b0 || data_out !== '0) begin
            errors++;
            $display("FAIL async_reset: valid=%b sof=%b eol=%b data=%h, want all 0",
                     out_valid, out_sof, out_eol, data_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        test_frame("rst_post", 4, 4, 3, 0, 9);
        idle();
    endtask

    task automatic test_five_lines();
        logic [5*DW-1:0] exp;
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 3; c++) begin
                push5((r == 0) && (c == 0), AW'(3), pix(0, r, c));
                checks++;
                if (r < 4) begin
                    if (out_valid5 !== 1'b0) begin
                        errors++;
                        $display("FAIL nl5 prime r%0d c%0d: out_valid=%b want 0", r, c, out_valid5);
                    end
                end else begin
                    exp = {pix(0, 0, c), pix(0, 1, c), pix(0, 2, c), pix(0, 3, c), pix(0, 4, c)};
                    if (out_valid5 !== 1'b1 || data_out5 !== exp ||
                        out_sof5 !== (c == 0) || out_eol5 !== (c == 2)) begin
                        errors++;
                        $display("FAIL nl5 r%0d c%0d: valid=%b sof=%b eol=%b data=%h, want 1 %b %b %h",
                                 r, c, out_valid5, out_sof5, out_eol5, data_out5, c == 0, c == 2, exp);
                    end
                end
            end
        end
        idle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_priming();
        test_backpressure();
        test_len_change();
        test_clamp();
        test_sof_mid();
        test_len1();
        test_async_reset();
        test_five_lines();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
